// File: rtl/dig_prog_clock_divider_if.sv
// Control/observe bundle for the programmable clock divider.
// The divider is the slave; whatever programs the rate is the master.
interface dig_prog_clock_divider_if #(
  parameter int Bits = 16
);
  logic            en;
  logic [Bits-1:0] div;
  logic            ld;
  logic            cout;
  logic            tick;
  logic            pend;
  logic [Bits-1:0] count;

  modport master (
    output en, div, ld,
    input  cout, tick, pend, count
  );

  modport slave (
    input  en, div, ld,
    output cout, tick, pend, count
  );
endinterface

// File: rtl/dig_prog_clock_divider.sv
// Runtime-programmable clock-enable generator: cout toggles and tick pulses at each
// terminal count; divisor loads are held until the next period boundary.
module dig_prog_clock_divider #(
  parameter int Bits       = 16,
  parameter int DefaultDiv = 1
) (
  input logic                      cin,
  input logic                      rst,
  dig_prog_clock_divider_if.slave  bus
);

  logic [Bits-1:0] cnt;
  logic [Bits-1:0] act;
  logic [Bits-1:0] nxt;
  logic            pendq;
  logic            coutq;
  logic            tickq;
  logic            tc;

  // act only changes at count==0, so an equality compare is sufficient
  assign tc = bus.en && (cnt == act);

  always_ff @(posedge cin) begin
    if (rst) begin
      cnt   <= '0;
      act   <= Bits'(DefaultDiv);
      nxt   <= '0;
      pendq <= 1'b0;
      coutq <= 1'b0;
      tickq <= 1'b0;
    end else begin
      tickq <= tc;

      if (tc) begin
        cnt   <= '0;
        coutq <= ~coutq;
      end else if (bus.en) begin
        cnt <= cnt + Bits'(1);
      end

      // a load on the boundary wins over (and discards) an older pending value
      if (tc && bus.ld) begin
        act   <= bus.div;
        pendq <= 1'b0;
      end else if (tc && pendq) begin
        act   <= nxt;
        pendq <= 1'b0;
      end else if (bus.ld) begin
        nxt   <= bus.div;
        pendq <= 1'b1;
      end
    end
  end

  assign bus.cout  = coutq;
  assign bus.tick  = tickq;
  assign bus.pend  = pendq;
  assign bus.count = cnt;

endmodule

// File: tb/tb_dig_prog_clock_divider.sv
// Scoreboard bench: each driven cycle pushes the reference model's expected outputs,
// and an independent monitor pops and compares them just after every rising edge.
module tb_dig_prog_clock_divider;

  localparam int Bits       = 4;
  localparam int DefaultDiv = 3;

  typedef struct {
    int count;
    int cout;
    int tick;
    int pend;
  } exp_t;

  logic cin;
  logic rst;

  dig_prog_clock_divider_if #(.Bits(Bits)) bus ();

  dig_prog_clock_divider #(
    .Bits       (Bits),
    .DefaultDiv (DefaultDiv)
  ) dut (
    .cin (cin),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb[$];
  exp_t monEntry;
  int   nChecks = 0;
  int   nFails  = 0;

  // reference model: position inside the current period, period length N,
  // number of completed periods, and a queue holding at most one pending divisor
  int mPos     = 0;
  int mN       = DefaultDiv;
  int mPeriods = 0;
  int mTick    = 0;
  int mPend[$];

  initial cin = 1'b0;
  always #5 cin = ~cin;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // drive one cycle of inputs and record what the outputs must be after the edge
  task automatic applyStimulus(input logic e, input logic l, input int d, input logic r);
    exp_t x;
    bit   boundary;
    @(negedge cin);
    rst     = r;
    bus.en  = e;
    bus.ld  = l;
    bus.div = Bits'(d);
    if (r) begin
      mPos     = 0;
      mN       = DefaultDiv;
      mPeriods = 0;
      mTick    = 0;
      mPend.delete();
    end else begin
      boundary = e && (mPos == mN);
      mTick    = boundary ? 1 : 0;
      if (boundary) begin
        mPos = 0;
        mPeriods++;
      end else if (e) begin
        mPos++;
      end
      if (boundary && l) begin
        mN = d;
        mPend.delete();
      end else if (boundary && mPend.size() > 0) begin
        mN = mPend.pop_front();
      end else if (l) begin
        mPend.delete();
        mPend.push_back(d);
      end
    end
    x.count = mPos;
    x.cout  = mPeriods % 2;
    x.tick  = mTick;
    x.pend  = (mPend.size() > 0) ? 1 : 0;
    sb.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, $urandom_range(15, 0), 1'b0);
  endtask

  task automatic runUntilPos(input int p);
    for (int i = 0; i < 40 && mPos != p; i++) idle(1);
  endtask

  always @(posedge cin) begin
    #1;
    if (sb.size() > 0) begin
      monEntry = sb.pop_front();
      checkOutput("count", int'(bus.count), monEntry.count);
      checkOutput("cout",  int'(bus.cout),  monEntry.cout);
      checkOutput("tick",  int'(bus.tick),  monEntry.tick);
      checkOutput("pend",  int'(bus.pend),  monEntry.pend);
    end
  end

  initial begin
    rst     = 1'b1;
    bus.en  = 1'b0;
    bus.ld  = 1'b0;
    bus.div = '0;

    applyStimulus(1'b0, 1'b0, 0, 1'b1);
    applyStimulus(1'b1, 1'b1, 9, 1'b1);

    $display("[TB] steady division with default divisor");
    idle(16);

    $display("[TB] reset with count=2, cout=1 and a pending load");
    for (int i = 0; i < 20 && !(mPos == 0 && (mPeriods % 2) == 1); i++) idle(1);
    applyStimulus(1'b1, 1'b1, 3, 1'b0);
    idle(1);
    applyStimulus(1'b1, 1'b1, 7, 1'b1);
    idle(12);

    $display("[TB] deferred load");
    runUntilPos(1);
    applyStimulus(1'b1, 1'b1, 1, 1'b0);
    idle(12);

    $display("[TB] second load while pending overwrites the first");
    runUntilPos(0);
    applyStimulus(1'b1, 1'b1, 3, 1'b0);
    runUntilPos(1);
    applyStimulus(1'b1, 1'b1, 1, 1'b0);
    applyStimulus(1'b1, 1'b1, 5, 1'b0);
    idle(20);

    $display("[TB] coincident load of divisor 0");
    runUntilPos(mN);
    applyStimulus(1'b1, 1'b1, 0, 1'b0);
    idle(8);
    applyStimulus(1'b1, 1'b1, 3, 1'b0);
    idle(6);

    $display("[TB] enable freeze with a load during the freeze");
    runUntilPos(2);
    applyStimulus(1'b0, 1'b0, 0, 1'b0);
    applyStimulus(1'b0, 1'b1, 2, 1'b0);
    applyStimulus(1'b0, 1'b0, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 0, 1'b0);
    idle(12);

    $display("[TB] full-width divisor");
    runUntilPos(mN);
    applyStimulus(1'b1, 1'b1, 15, 1'b0);
    idle(70);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 1500; i++) begin
      automatic logic e = ($urandom_range(99, 0) < 85);
      automatic logic l = ($urandom_range(99, 0) < 6);
      automatic logic r = ($urandom_range(999, 0) < 5);
      automatic int   d = ($urandom_range(3, 0) == 0) ? $urandom_range(15, 0)
                                                      : $urandom_range(3, 0);
      applyStimulus(e, l, d, r);
    end

    @(posedge cin);
    #2;
    checkOutput("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/dig_prog_clock_divider.md
# dig_prog_clock_divider

Runtime-programmable clock-enable generator: divides the input clock by a divisor that can be changed on the fly. It produces a toggling output (`cout`, period 2·(N+1) cycles) and a one-cycle terminal-count strobe (`tick`) for use as a clock enable. Divisor changes are deferred to the next period boundary, so no output period is ever truncated. It sits next to the fixed-divisor divider and replaces it wherever the rate must be set by logic or software.

## Interface
Parameters:
- `Bits`, 16: width of the counter and the divisor (1..32).
- `DefaultDiv`, 1: active divisor after reset; must fit in `Bits`.

Ports:
- `cin` input 1: clock; all state changes on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `en` input 1: count enable; when low, the divider freezes.
- `div` input `Bits`: new divisor value N; sampled only when `ld`=1.
- `ld` input 1: load request for `div`; single-cycle or level (level reloads every cycle).
- `cout` output 1: divided clock, toggles at each terminal count.
- `tick` output 1: registered strobe, high for the cycle after each terminal count.
- `pend` output 1: a loaded divisor is waiting for the next boundary.
- `count` output `Bits`: current counter value (debug/observe).

## Operation
- State registers:
  - `count`: counter.
  - `act`: active divisor N.
  - `nxt`: pending divisor.
  - `pend`: pending flag.
  - `cout`.
  - `tick`.
- Terminal condition `tc` = `en` & (`count` == `act`). It is combinational and internal.
- Rising edge with `rst`=1:
  - `count`=0, `act`=`DefaultDiv`, `nxt`=0, `pend`=0, `cout`=0, `tick`=0.
  - `rst` overrides everything else, including `ld` and any pending load.
- Rising edge with `rst`=0:
  - `tick` <= `tc`.
  - If `tc`: `count` <= 0 and `cout` <= ~`cout`.
  - Else if `en`: `count` <= `count`+1.
  - Else: `count` holds.
- Divisor update, in priority order:
  1. `tc` & `ld`: `act` <= `div`, `pend` <= 0. The new value takes effect on this boundary, and any older pending value is discarded.
  2. `tc` & `pend`: `act` <= `nxt`, `pend` <= 0.
  3. `ld` (no `tc`): `nxt` <= `div`, `pend` <= 1. A later `ld` before the boundary overwrites `nxt` (last write wins).
- `act` changes only when `count` returns to 0, so `count` ≤ `act` always holds and no wrap-around compare is needed. `count`+1 never overflows `Bits`.
- N=0: `tc` is true every enabled cycle. `tick` stays high continuously and `cout` toggles every cycle (`cin`/2).
- `en`=0:
  - `count`, `cout` and `act` hold, and `tick` is 0 from the next edge.
  - `ld` is still captured into `nxt`/`pend`. No boundary occurs, so `pend` stays 1 until `en` returns and a terminal count is reached.
- Arithmetic is unsigned and `div` is taken at full `Bits` width; there is no saturation.

## Timing
- All outputs are registered and have no combinational path from any input.
- Reset values: `cout`=0, `tick`=0, `pend`=0, `count`=0.
- Edge numbering: edge 0 is the first edge with `rst`=0. With `en`=1 and divisor N:
  - `tc` occurs at edges N, 2N+1, 3N+2, …
  - `tick` and `cout` change immediately after those edges.
- With N ≥ 1, `tick` is high for exactly 1 cycle per period of N+1 cycles. `cout` has a 50 % duty cycle and a period of 2·(N+1) cycles.
- Load latency:
  - With `ld` at an edge where `tc`=1: the new N governs the very next period.
  - Otherwise the new N governs the period after the current one. `pend` rises the cycle after `ld` and falls the cycle after the applying boundary.
- `en` deasserted at edge k: the edge-k update is suppressed. Counting resumes from the frozen `count` on the first edge with `en`=1, so the period is stretched by exactly the number of disabled cycles.

## Test plan
- Reset: run 10 cycles with `DefaultDiv`=3, then assert `rst` for 1 edge at `count`=2 with `cout`=1 and `pend`=1 -> after that edge `count`=0, `cout`=0, `tick`=0, `pend`=0, `act`=3.
- Steady division: `DefaultDiv`=3, `en`=1 -> `tick` high after edges 3, 7, 11 only; `cout` reads 1, 0, 1 after those edges (period 8); `count` sequence is 0,1,2,3,0.
- Deferred load: with `act`=3, pulse `ld` with `div`=1 at `count`=1 -> `pend`=1 next cycle; the current period still ends at `count`=3; then `tick` occurs every 2 cycles and `pend`=0. A second `ld` (`div`=5) while pending -> 5 is applied, not 1.
- Coincident load: pulse `ld` with `div`=0 on the `tc` edge -> `pend` never rises; from the next cycle `tick`=1 continuously and `cout` toggles every cycle.
- Enable freeze: with `act`=3, drop `en` for 4 cycles at `count`=2 and issue `ld`(`div`=2) during the freeze -> `count` holds 2, `tick`=0, `cout` is stable and `pend`=1; after `en`=1 the terminal count follows 2 cycles later, then the period is 3.
- Width edge: `Bits`=4, `div`=15 -> `count` reaches 15, wraps to 0 via `tc`, `cout` period is 32, with no overflow glitch.
